gcd_ctrl: RTL and testbench



---
 rtl/gcd_ctrl.sv | 95 +++++++++
 tb/tb_gcd_ctrl.sv | 121 ++++++++++++
 2 files changed

// File: rtl/gcd_ctrl.sv
// gcd_ctrl: control FSM for the subtract-and-swap GCD datapath with an iteration watchdog.
// Define GCD_CTRL_ITER_CNT_EN to expose the iteration counter on iter_cnt_o.
module gcd_ctrl #(
    parameter int CNT_W    = 10,
    parameter int MAX_ITER = 1023
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             operands_val,
    output logic             operands_rdy,
    output logic             result_val,
    input  logic             result_rdy,
    input  logic             B_zero,
    input  logic             A_lt_B,
    output logic             A_en,
    output logic             B_en,
    output logic [1:0]       A_mux_sel,
    output logic             B_mux_sel,
    output logic             busy,
    output logic             result_err
`ifdef GCD_CTRL_ITER_CNT_EN
    ,
    output logic [CNT_W-1:0] iter_cnt_o
`endif
);
    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
    localparam logic [CNT_W-1:0] cnt_max = CNT_W'(MAX_ITER);
    state_t           state, state_nxt;
    logic [CNT_W-1:0] iter_cnt, cnt_nxt;
    logic             err, err_nxt;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            iter_cnt <= '0;
            err      <= 1'b0;
        end else begin
            state    <= state_nxt;
            iter_cnt <= cnt_nxt;
            err      <= err_nxt;
        end
    end
    // Outputs are gated by rst_n so everything reads 0 while reset is held.
    always_comb begin
        state_nxt    = state;
        cnt_nxt      = iter_cnt;
        err_nxt      = err;
        operands_rdy = 1'b0;
        result_val   = 1'b0;
        result_err   = 1'b0;
        busy         = 1'b0;
        A_en         = 1'b0;
        B_en         = 1'b0;
        A_mux_sel    = 2'b00;
        B_mux_sel    = 1'b0;
        if (rst_n) begin
            case (state)
                IDLE: begin
                    operands_rdy = 1'b1;
                    if (operands_val) begin
                        A_en      = 1'b1;
                        B_en      = 1'b1;
                        B_mux_sel = 1'b1;
                        cnt_nxt   = '0;
                        err_nxt   = 1'b0;
                        state_nxt = CALC;
                    end
                end
                CALC: begin
                    busy = 1'b1;
                    if (B_zero) begin
                        err_nxt   = 1'b0;
                        state_nxt = DONE;
                    end else if (iter_cnt == cnt_max) begin
                        err_nxt   = 1'b1;
                        state_nxt = DONE;
                    end else begin
                        A_en      = 1'b1;
                        B_en      = A_lt_B;
                        A_mux_sel = A_lt_B ? 2'b10 : 2'b01;
                        cnt_nxt   = iter_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    result_val = 1'b1;
                    result_err = err;
                    if (result_rdy) state_nxt = IDLE;
                end
                default: state_nxt = IDLE;
            endcase
        end
    end
`ifdef GCD_CTRL_ITER_CNT_EN
    assign iter_cnt_o = iter_cnt;
`endif
endmodule

// File: tb/tb_gcd_ctrl.sv
// tb_gcd_ctrl: directed bench; three controllers (MAX_ITER 1023/4/5) each drive a behavioural GCD datapath.
module tb_gcd_ctrl;
    localparam int MI [3] = '{1023, 4, 5};
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] op_a = '0, op_b = '0;
    logic [2:0] ov = '0, rr = '0;
    logic [2:0] ordy, rv, aen, ben, bms, bsy, rerr;
    logic [2:0][1:0] ams;
    logic [2:0][15:0] res;
`ifdef GCD_CTRL_ITER_CNT_EN
    logic [2:0][9:0] ic;
`endif
    int total = 0, bad = 0;
    logic [14:0] seq;
    int nops;
    always #5 clk = ~clk;
    for (genvar g = 0; g < 3; g++) begin : gi
        logic [15:0] a_q = '0, b_q = '0;
        gcd_ctrl #(.CNT_W(10), .MAX_ITER(MI[g])) u (
            .clk(clk), .rst_n(rst_n),
            .operands_val(ov[g]), .operands_rdy(ordy[g]),
            .result_val(rv[g]), .result_rdy(rr[g]),
            .B_zero(b_q == 16'd0), .A_lt_B(a_q < b_q),
            .A_en(aen[g]), .B_en(ben[g]), .A_mux_sel(ams[g]), .B_mux_sel(bms[g]),
            .busy(bsy[g]), .result_err(rerr[g])
`ifdef GCD_CTRL_ITER_CNT_EN
            , .iter_cnt_o(ic[g])
`endif
        );
        always_ff @(posedge clk) begin
            if (aen[g]) a_q <= (ams[g] == 2'b00) ? op_a : (ams[g] == 2'b01) ? a_q - b_q : b_q;
            if (ben[g]) b_q <= bms[g] ? op_b : a_q;
        end
        assign res[g] = a_q;
    end
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask
    task automatic run(input int i, input int a, input int b, input int res_e, input int err_e,
                       input int lat_e, input int cnt_e, input int hold);
        int lat;
        logic e0;
        @(negedge clk);
        op_a = 16'(a);
        op_b = 16'(b);
        chk("rdy_before_load", 32'(ordy[i]), 1);
        ov[i] = 1'b1;
        #1 chk("load_ctrl", {aen[i], ben[i], ams[i], bms[i]}, 32'b11001);
        @(negedge clk);
        ov[i] = 1'b0;
        lat = 1;
        seq = '0;
        nops = 0;
        while (!rv[i] && lat < 2000) begin
            if (aen[i]) begin
                seq = {seq[11:0], ben[i], ams[i]};
                nops++;
            end
            @(negedge clk);
            lat++;
        end
        chk("latency", 32'(lat), 32'(lat_e));
        chk("result", 32'(res[i]), 32'(res_e));
        chk("result_err", 32'(rerr[i]), 32'(err_e));
`ifdef GCD_CTRL_ITER_CNT_EN
        chk("iter_cnt_o", 32'(ic[i]), 32'(cnt_e));
`else
        chk("iterations", 32'(nops), 32'(cnt_e));
`endif
        e0 = rerr[i];
        repeat (hold) begin
            ov[i] = 1'b1;
            @(negedge clk);
            chk("hold_val", {rv[i], rerr[i], aen[i], ben[i], ordy[i]}, {1'b1, e0, 3'b000});
        end
        ov[i] = 1'b0;
        rr[i] = 1'b1;
        @(negedge clk);
        rr[i] = 1'b0;
        chk("back_idle", {ordy[i], rv[i], bsy[i]}, 32'b100);
    endtask
    initial begin
        ov[0] = 1'b1;
        #2 chk("in_reset", {ordy, rv, aen, ben, bsy}, 0);
        ov[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        op_a = 16'd12;
        op_b = 16'd8;
        ov[0] = 1'b1;
        @(negedge clk);
        ov[0] = 1'b0;
        @(negedge clk);
        chk("busy_mid_calc", 32'(bsy[0]), 1);
        #2 rst_n = 1'b0;
        #1 chk("reset_abort", {ordy[0], rv[0], aen[0], ben[0], bsy[0], ams[0], bms[0]}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("after_reset", {ordy[0], rv[0], bsy[0]}, 32'b100);
        run(0, 12, 8, 4, 0, 7, 5, 0);
        chk("op_count", 32'(nops), 5);
        chk("op_sequence", 32'(seq), 32'b001_110_001_001_110);
        run(0, 7, 0, 7, 0, 2, 0, 0);
        run(0, 0, 5, 5, 0, 3, 1, 0);
        chk("zero_a_swap", 32'(seq[2:0]), 32'b110);
        run(1, 12, 8, 0, 1, 6, 4, 0);
        run(2, 12, 8, 4, 0, 7, 5, 0);
        run(0, 12, 8, 4, 0, 7, 5, 10);
        run(0, 255, 1, 1, 0, 258, 256, 0);
        run(0, 0, 0, 0, 0, 2, 0, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
